// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry flop,
// LSB first, one bit per clock, with valid/ready handshakes on operands and result.
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             fa_s, fa_co;

  always_comb begin
    fa_s  = sa_q[0] ^ sb_q[0] ^ carry_q;
    fa_co = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
    res_d = {fa_s, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction as A + ~B + 1: the +1 enters through the carry flop.
            sa_q    <= a;
            sb_q    <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          res_q   <= res_d;
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            // carry_q here is the carry into the MSB.
            sum_q   <= res_d;
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
